tw4_core: RTL and testbench

Parametrised TW4 processor core: a single-cycle, two-register (A, B) accumulator machine with carry flag, program counter, input port and latched output port. Generalised in data and address width, with a real carry/JNC path, a fetch-valid stall handshake, an optional input synchronizer and an output-update strobe. Sits between an asynchronous program ROM, which returns the instruction for `addr` combinationally, and board-level I/O.

---
 rtl/tw4_core.sv | 117 +++++++++++
 tb/tb_tw4_core.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tw4_core.sv
// TW4 accumulator core: A/B registers, carry flag, PC, input port and
// latched output port, one instruction per clock when the fetch is valid.
module tw4_core #(
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 4,
    parameter bit SYNC_IN = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    output logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W+3:0]   instr,
    input  logic                instr_valid,
    input  logic [DATA_W-1:0]   in,
    output logic [DATA_W-1:0]   out,
    output logic                out_strobe,
    output logic                carry
);

    logic [3:0]        op;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] in_s;
    logic [ADDR_W-1:0] tgt;
    logic [DATA_W:0]   sum_a;
    logic [DATA_W:0]   sum_b;

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              c_q, c_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              stb_q, stb_d;

    assign op    = instr[DATA_W+3:DATA_W];
    assign imm   = instr[DATA_W-1:0];
    assign tgt   = ADDR_W'(imm);
    assign sum_a = {1'b0, a_q} + {1'b0, imm};
    assign sum_b = {1'b0, b_q} + {1'b0, imm};

    // The synchronizer samples every cycle, stalled or not.
    generate
        if (SYNC_IN) begin : g_sync
            logic [DATA_W-1:0] s1_q;
            logic [DATA_W-1:0] s2_q;
            always_ff @(posedge clock) begin
                if (reset) begin
                    s1_q <= '0;
                    s2_q <= '0;
                end else begin
                    s1_q <= in;
                    s2_q <= s1_q;
                end
            end
            assign in_s = s2_q;
        end else begin : g_raw
            assign in_s = in;
        end
    endgenerate

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        pc_d  = pc_q;
        out_d = out_q;
        stb_d = 1'b0;
        if (instr_valid) begin
            c_d  = 1'b0;
            pc_d = pc_q + ADDR_W'(1);
            case (op)
                4'h0: {c_d, a_d} = sum_a;
                4'h1: a_d = b_q;
                4'h2: a_d = in_s;
                4'h3: a_d = imm;
                4'h4: b_d = a_q;
                4'h5: {c_d, b_d} = sum_b;
                4'h6: b_d = in_s;
                4'h7: b_d = imm;
                4'h9: begin
                    out_d = b_q;
                    stb_d = 1'b1;
                end
                4'hB: begin
                    out_d = imm;
                    stb_d = 1'b1;
                end
                4'hE: pc_d = tgt;
                // JNC tests the carry left by the previous instruction.
                4'hF: if (!c_q) pc_d = tgt;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= 1'b0;
            pc_q  <= '0;
            out_q <= '0;
            stb_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            pc_q  <= pc_d;
            out_q <= out_d;
            stb_q <= stb_d;
        end
    end

    assign addr       = pc_q;
    assign out        = out_q;
    assign out_strobe = stb_q;
    assign carry      = c_q;

endmodule

// File: tb/tb_tw4_core.sv
// Directed scoreboard bench for tw4_core: a 4/4 synchronized instance and
// an 8/6 raw-input instance, each fed from a small ROM array.
module tb_tw4_core;

    typedef struct {
        string      tag;
        int         dut;
        logic [7:0] addr;
        logic [7:0] out;
        logic       stb;
        logic       cy;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   failed = 0;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst0, v0;
    logic [3:0] in0, addr0, out0;
    logic [7:0] instr0;
    logic       stb0, cy0;
    logic [7:0] rom0 [16];
    assign instr0 = rom0[addr0];

    logic        rst1, v1;
    logic [7:0]  in1, out1;
    logic [5:0]  addr1;
    logic [11:0] instr1;
    logic        stb1, cy1;
    logic [11:0] rom1 [64];
    assign instr1 = rom1[addr1];

    tw4_core #(.DATA_W(4), .ADDR_W(4), .SYNC_IN(1'b1)) u0 (
        .clock(clock), .reset(rst0), .addr(addr0), .instr(instr0),
        .instr_valid(v0), .in(in0), .out(out0), .out_strobe(stb0),
        .carry(cy0)
    );

    tw4_core #(.DATA_W(8), .ADDR_W(6), .SYNC_IN(1'b0)) u1 (
        .clock(clock), .reset(rst1), .addr(addr1), .instr(instr1),
        .instr_valid(v1), .in(in1), .out(out1), .out_strobe(stb1),
        .carry(cy1)
    );

    task automatic push(input string tag, input int dut, input logic [7:0] a,
                        input logic [7:0] o, input logic s, input logic c);
        exp_t e;
        e.tag = tag; e.dut = dut; e.addr = a; e.out = o; e.stb = s; e.cy = c;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        logic [7:0] oa, oo;
        logic os, oc;
        @(posedge clock);
        #1;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (e.dut == 0) begin
            oa = {4'b0, addr0}; oo = {4'b0, out0}; os = stb0; oc = cy0;
        end else begin
            oa = {2'b0, addr1}; oo = out1; os = stb1; oc = cy1;
        end
        tests += 4;
        assert (oa === e.addr) else begin
            failed++;
            $error("FAIL %s addr got %h exp %h", e.tag, oa, e.addr);
        end
        assert (oo === e.out) else begin
            failed++;
            $error("FAIL %s out got %h exp %h", e.tag, oo, e.out);
        end
        assert (os === e.stb) else begin
            failed++;
            $error("FAIL %s strobe got %b exp %b", e.tag, os, e.stb);
        end
        assert (oc === e.cy) else begin
            failed++;
            $error("FAIL %s carry got %b exp %b", e.tag, oc, e.cy);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom0[i] = 8'h80;
        for (int i = 0; i < 64; i++) rom1[i] = 12'h800;
        rom0[0]  = 8'h3E;  // MOV A,E
        rom0[1]  = 8'h03;  // ADD A,3
        rom0[2]  = 8'hF9;  // JNC 9
        rom0[3]  = 8'h40;  // MOV B,A
        rom0[4]  = 8'h90;  // OUT B
        rom0[5]  = 8'hF8;  // JNC 8
        rom0[8]  = 8'h7A;  // MOV B,A
        rom0[9]  = 8'h90;  // OUT B
        rom0[10] = 8'hB3;  // OUT 3
        rom0[11] = 8'h80;  // NOP
        rom0[12] = 8'hEF;  // JMP F
        rom0[15] = 8'h80;  // NOP
        rst0 = 1'b1; v0 = 1'b0; in0 = '0;
        rst1 = 1'b1; v1 = 1'b0; in1 = '0;

        push("rst_a", 0, 0, 0, 0, 0); tick();
        push("rst_b", 0, 0, 0, 0, 0); tick();
        rst0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push("stall", 0, 0, 0, 0, 0); tick();
        end

        v0 = 1'b1;
        push("mov_a", 0, 1, 0, 0, 0); tick();
        push("add_cy", 0, 2, 0, 0, 1); tick();
        v0 = 1'b0;
        push("stall_cy", 0, 2, 0, 0, 1); tick();
        v0 = 1'b1;
        push("jnc_nt", 0, 3, 0, 0, 0); tick();
        push("mov_ba", 0, 4, 0, 0, 0); tick();
        v0 = 1'b0;
        push("stall_out", 0, 4, 0, 0, 0); tick();
        v0 = 1'b1;
        push("out_a", 0, 5, 1, 1, 0); tick();
        push("jnc_t", 0, 8, 1, 0, 0); tick();
        push("mov_b", 0, 9, 1, 0, 0); tick();
        push("out_b", 0, 10, 8'hA, 1, 0); tick();
        push("out_imm", 0, 11, 3, 1, 0); tick();
        push("nop_stb", 0, 12, 3, 0, 0); tick();
        push("jmp", 0, 15, 3, 0, 0); tick();
        push("wrap", 0, 0, 3, 0, 0); tick();

        rst0 = 1'b1; v0 = 1'b0;
        rom0[0] = 8'h20;  // IN A
        rom0[1] = 8'h60;  // IN B
        rom0[2] = 8'h90;  // OUT B
        rom0[3] = 8'h40;  // MOV B,A
        rom0[4] = 8'h90;  // OUT B
        rom0[5] = 8'h5F;  // ADD B,F
        rom0[6] = 8'h51;  // ADD B,1
        rom0[7] = 8'h90;  // OUT B
        push("rst2", 0, 0, 0, 0, 0); tick();
        rst0 = 1'b0; in0 = 4'h6;
        push("sync_k", 0, 0, 0, 0, 0); tick();
        v0 = 1'b1;
        push("in_a_k1", 0, 1, 0, 0, 0); tick();
        push("in_b_k2", 0, 2, 0, 0, 0); tick();
        push("out_in_b", 0, 3, 6, 1, 0); tick();
        push("mov_ba2", 0, 4, 6, 0, 0); tick();
        push("out_in_a", 0, 5, 0, 1, 0); tick();
        push("add_nc", 0, 6, 0, 0, 0); tick();
        push("add_wrap", 0, 7, 0, 0, 1); tick();
        push("out_wrap", 0, 8, 0, 1, 0); tick();

        rst0 = 1'b1; v0 = 1'b0;
        rom1[0] = 12'hEC5;  // JMP C5
        rom1[5] = 12'h3F0;  // MOV A,F0
        rom1[6] = 12'h020;  // ADD A,20
        rom1[7] = 12'h600;  // IN B
        rom1[8] = 12'h900;  // OUT B
        rom1[9] = 12'hB11;  // OUT 11
        push("w_rst", 1, 0, 0, 0, 0); tick();
        rst1 = 1'b0; v1 = 1'b1; in1 = 8'h77;
        push("w_jmp", 1, 5, 0, 0, 0); tick();
        push("w_mov", 1, 6, 0, 0, 0); tick();
        push("w_add", 1, 7, 0, 0, 1); tick();
        push("w_in", 1, 8, 0, 0, 0); tick();
        push("w_out", 1, 9, 8'h77, 1, 0); tick();
        rst1 = 1'b1;
        push("w_midrst", 1, 0, 0, 0, 0); tick();
        rst1 = 1'b0;
        push("w_rejmp", 1, 5, 0, 0, 0); tick();
        push("w_remov", 1, 6, 0, 0, 0); tick();
        push("w_readd", 1, 7, 0, 0, 1); tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
